block_sync: RTL and testbench

Receive-side 64b/66b block synchroniser for the 25G lane decoder, running at one 66-bit block per clock. It sits between the RX gearbox and the descrambler/frame checker: it hunts for valid sync headers, requests bit slips from the gearbox until alignment holds, and declares lock. It then forwards the sync header and payload with a `block_sync_rdy` qualifier, which gates downstream frame checking.

---
 rtl/block_sync.sv | 145 ++++++++++++++
 tb/tb_block_sync.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/block_sync.sv
// 64b/66b receive block synchroniser: hunts for sync headers, requests gearbox slips, declares lock.
// Optional header error counter is enabled by defining BLOCK_SYNC_HDR_ERR_CNT_EN.
module block_sync #(
    parameter int LOCK_CNT   = 64,
    parameter int ERR_WIN    = 64,
    parameter int ERR_THRESH = 16,
    parameter int SLIP_WAIT  = 4
) (
    input  logic        clk_390p625M,
    input  logic        rst_n,
    input  logic [65:0] rx_block,
    input  logic        rx_block_vld,
    output logic        slip,
    output logic        block_sync_rdy,
    output logic [1:0]  sync_head,
    output logic [63:0] block_payload,
    output logic        block_vld,
    output logic [15:0] hdr_err_count
);

    localparam logic [9:0] LOCK_TGT   = 10'(LOCK_CNT);
    localparam logic [9:0] WIN_TGT    = 10'(ERR_WIN);
    localparam logic [9:0] THRESH_TGT = 10'(ERR_THRESH);
    localparam logic [3:0] WAIT_LOAD  = 4'(SLIP_WAIT);

    typedef enum logic [1:0] {HUNT, LOCKED, SLIP_HOLD} state_t;

    state_t     state, state_nxt;
    logic [9:0] good_cnt, good_nxt;
    logic [9:0] win_cnt, win_nxt;
    logic [9:0] bad_cnt, bad_nxt;
    logic [3:0] wait_cnt, wait_nxt;
    logic       slip_nxt;
    logic       hdr_ok;

    // A valid sync header has exactly one bit set (01 or 10).
    assign hdr_ok = rx_block[65] ^ rx_block[64];

    always_comb begin
        state_nxt = state;
        good_nxt  = good_cnt;
        win_nxt   = win_cnt;
        bad_nxt   = bad_cnt;
        wait_nxt  = wait_cnt;
        slip_nxt  = 1'b0;
        if (rx_block_vld) begin
            case (state)
                HUNT: begin
                    if (!hdr_ok) begin
                        slip_nxt  = 1'b1;
                        good_nxt  = '0;
                        wait_nxt  = WAIT_LOAD;
                        state_nxt = SLIP_HOLD;
                    end else if (good_cnt + 10'd1 == LOCK_TGT) begin
                        good_nxt  = '0;
                        win_nxt   = '0;
                        bad_nxt   = '0;
                        state_nxt = LOCKED;
                    end else begin
                        good_nxt = good_cnt + 10'd1;
                    end
                end
                LOCKED: begin
                    // Hitting the error threshold wins over a window boundary on the same block.
                    if (!hdr_ok && (bad_cnt + 10'd1 == THRESH_TGT)) begin
                        slip_nxt  = 1'b1;
                        win_nxt   = '0;
                        bad_nxt   = '0;
                        wait_nxt  = WAIT_LOAD;
                        state_nxt = SLIP_HOLD;
                    end else if (win_cnt + 10'd1 == WIN_TGT) begin
                        win_nxt = '0;
                        bad_nxt = '0;
                    end else begin
                        win_nxt = win_cnt + 10'd1;
                        bad_nxt = bad_cnt + {9'd0, ~hdr_ok};
                    end
                end
                SLIP_HOLD: begin
                    if (wait_cnt <= 4'd1) begin
                        wait_nxt  = '0;
                        good_nxt  = '0;
                        state_nxt = HUNT;
                    end else begin
                        wait_nxt = wait_cnt - 4'd1;
                    end
                end
                default: state_nxt = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk_390p625M or negedge rst_n) begin
        if (!rst_n) begin
            state    <= HUNT;
            good_cnt <= '0;
            win_cnt  <= '0;
            bad_cnt  <= '0;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            good_cnt <= good_nxt;
            win_cnt  <= win_nxt;
            bad_cnt  <= bad_nxt;
            wait_cnt <= wait_nxt;
        end
    end

    // Lock status is registered with the data so it qualifies the block it belongs to.
    always_ff @(posedge clk_390p625M or negedge rst_n) begin
        if (!rst_n) begin
            slip           <= 1'b0;
            block_sync_rdy <= 1'b0;
            sync_head      <= '0;
            block_payload  <= '0;
            block_vld      <= 1'b0;
        end else begin
            slip           <= slip_nxt;
            block_sync_rdy <= (state_nxt == LOCKED);
            block_vld      <= rx_block_vld;
            if (rx_block_vld) begin
                sync_head     <= rx_block[65:64];
                block_payload <= rx_block[63:0];
            end
        end
    end

`ifdef BLOCK_SYNC_HDR_ERR_CNT_EN
    logic [15:0] err_cnt;

    // Headers seen while waiting out a slip are misaligned by design and are not counted.
    always_ff @(posedge clk_390p625M or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= '0;
        end else if (rx_block_vld && !hdr_ok && (state != SLIP_HOLD) && (err_cnt != 16'hFFFF)) begin
            err_cnt <= err_cnt + 16'd1;
        end
    end

    assign hdr_err_count = err_cnt;
`else
    assign hdr_err_count = '0;
`endif

endmodule

// File: tb/tb_block_sync.sv
// Self-checking bench for block_sync: block-level reference model plus directed scenarios.
// Honours BLOCK_SYNC_HDR_ERR_CNT_EN for the expected error-counter behaviour.
module tb_block_sync;

    localparam int LOCK_CNT   = 64;
    localparam int ERR_WIN    = 64;
    localparam int ERR_THRESH = 16;
    localparam int SLIP_WAIT  = 4;

    logic        clk_390p625M = 1'b0;
    logic        rst_n = 1'b0;
    logic [65:0] rx_block = '0;
    logic        rx_block_vld = 1'b0;
    logic        slip;
    logic        block_sync_rdy;
    logic [1:0]  sync_head;
    logic [63:0] block_payload;
    logic        block_vld;
    logic [15:0] hdr_err_count;

    int errors = 0;
    int checks = 0;
    int slip_pulses = 0;

    block_sync #(
        .LOCK_CNT(LOCK_CNT), .ERR_WIN(ERR_WIN), .ERR_THRESH(ERR_THRESH), .SLIP_WAIT(SLIP_WAIT)
    ) dut (
        .clk_390p625M(clk_390p625M),
        .rst_n(rst_n),
        .rx_block(rx_block),
        .rx_block_vld(rx_block_vld),
        .slip(slip),
        .block_sync_rdy(block_sync_rdy),
        .sync_head(sync_head),
        .block_payload(block_payload),
        .block_vld(block_vld),
        .hdr_err_count(hdr_err_count)
    );

    always #5 clk_390p625M = ~clk_390p625M;

    // Reference model: mode 0 = hunting, 1 = locked, 2 = waiting after a slip.
    int          m_mode = 0, m_run = 0, m_win = 0, m_bad = 0, m_hold = 0;
    int          m_errs = 0;
    logic        exp_slip = 0, exp_rdy = 0, exp_vld = 0;
    logic [1:0]  exp_head = '0;
    logic [63:0] exp_payload = '0;

    always @(posedge clk_390p625M or negedge rst_n) begin
        if (!rst_n) begin
            m_mode = 0; m_run = 0; m_win = 0; m_bad = 0; m_hold = 0; m_errs = 0;
            exp_slip = 0; exp_rdy = 0; exp_vld = 0; exp_head = '0; exp_payload = '0;
        end else begin
            bit good;
            good = (rx_block[65:64] == 2'b01) || (rx_block[65:64] == 2'b10);
            exp_slip = 0;
            exp_vld = rx_block_vld;
            if (rx_block_vld) begin
                exp_head = rx_block[65:64];
                exp_payload = rx_block[63:0];
                if (!good && m_mode != 2 && m_errs < 65535) m_errs++;
                if (m_mode == 0) begin
                    if (!good) begin
                        exp_slip = 1; m_run = 0; m_hold = SLIP_WAIT; m_mode = 2;
                    end else begin
                        m_run++;
                        if (m_run == LOCK_CNT) begin
                            m_mode = 1; m_run = 0; m_win = 0; m_bad = 0;
                        end
                    end
                end else if (m_mode == 1) begin
                    m_win++;
                    if (!good) m_bad++;
                    if (m_bad == ERR_THRESH) begin
                        exp_slip = 1; m_mode = 2; m_hold = SLIP_WAIT; m_win = 0; m_bad = 0;
                    end else if (m_win == ERR_WIN) begin
                        m_win = 0; m_bad = 0;
                    end
                end else begin
                    m_hold--;
                    if (m_hold == 0) begin
                        m_mode = 0; m_run = 0;
                    end
                end
            end
            exp_rdy = (m_mode == 1);
        end
    end

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] model_err_count();
`ifdef BLOCK_SYNC_HDR_ERR_CNT_EN
        return 16'(m_errs);
`else
        return 16'd0;
`endif
    endfunction

    // Every-cycle comparison against the model, away from the active edge.
    always @(posedge clk_390p625M) begin
        #1;
        if (slip === 1'b1) slip_pulses++;
        check_output("slip", {63'd0, slip}, {63'd0, exp_slip});
        check_output("rdy", {63'd0, block_sync_rdy}, {63'd0, exp_rdy});
        check_output("vld", {63'd0, block_vld}, {63'd0, exp_vld});
        check_output("head", {62'd0, sync_head}, {62'd0, exp_head});
        check_output("payload", block_payload, exp_payload);
        check_output("errcnt", {48'd0, hdr_err_count}, {48'd0, model_err_count()});
    end

    task automatic apply_stimulus(input logic [1:0] hdr, input logic vld);
        @(negedge clk_390p625M);
        rx_block = {hdr, $urandom, $urandom};
        rx_block_vld = vld;
    endtask

    task automatic settle();
        @(posedge clk_390p625M);
        #2;
    endtask

    task automatic do_reset();
        @(negedge clk_390p625M);
        rst_n = 1'b0;
        rx_block_vld = 1'b0;
        #1;
        check_output("rst_slip", {63'd0, slip}, 64'd0);
        check_output("rst_rdy", {63'd0, block_sync_rdy}, 64'd0);
        check_output("rst_vld", {63'd0, block_vld}, 64'd0);
        check_output("rst_head", {62'd0, sync_head}, 64'd0);
        check_output("rst_payload", block_payload, 64'd0);
        check_output("rst_errcnt", {48'd0, hdr_err_count}, 64'd0);
        repeat (2) @(posedge clk_390p625M);
        @(negedge clk_390p625M);
        rst_n = 1'b1;
    endtask

    initial begin
        int base;
        do_reset();

        // Lock from alternating valid headers.
        for (int i = 0; i < 63; i++) apply_stimulus(i % 2 ? 2'b10 : 2'b01, 1'b1);
        settle();
        check_output("lock_pre", {63'd0, block_sync_rdy}, 64'd0);
        apply_stimulus(2'b10, 1'b1);
        settle();
        check_output("lock_rise", {63'd0, block_sync_rdy}, 64'd1);
        check_output("lock_noslip", 64'(slip_pulses), 64'd0);

        // Three windows with 15 errors each keep lock.
        for (int w = 0; w < 3; w++) begin
            for (int j = 0; j < 64; j++)
                apply_stimulus((j % 4 == 0 && j < 60) ? 2'b11 : 2'b01, 1'b1);
            settle();
            check_output("win_rdy", {63'd0, block_sync_rdy}, 64'd1);
        end
        check_output("win_noslip", 64'(slip_pulses), 64'd0);

        // Sixteen errors within 39 blocks drop lock on the 16th.
        for (int i = 0; i < 39; i++) begin
            apply_stimulus((i % 5 == 1 || i % 5 == 3) ? 2'b00 : 2'b10, 1'b1);
            if (i == 36) begin
                settle();
                check_output("loss_pre", {63'd0, block_sync_rdy}, 64'd1);
            end
        end
        settle();
        check_output("loss_rdy", {63'd0, block_sync_rdy}, 64'd0);
        check_output("loss_slip", {63'd0, slip}, 64'd1);
        for (int i = 0; i < 4; i++) apply_stimulus(2'b01, 1'b1);

        // Hunt slip: 10 good, one bad, 4 ignored, then 64 good to lock.
        base = slip_pulses;
        for (int i = 0; i < 10; i++) apply_stimulus(2'b01, 1'b1);
        apply_stimulus(2'b11, 1'b1);
        settle();
        check_output("hunt_slip", {63'd0, slip}, 64'd1);
        apply_stimulus(2'b01, 1'b1);
        settle();
        check_output("hunt_slip_end", {63'd0, slip}, 64'd0);
        for (int i = 0; i < 3; i++) apply_stimulus(2'b10, 1'b1);
        for (int i = 0; i < 63; i++) apply_stimulus(2'b01, 1'b1);
        settle();
        check_output("hunt_pre", {63'd0, block_sync_rdy}, 64'd0);
        apply_stimulus(2'b01, 1'b1);
        settle();
        check_output("hunt_lock", {63'd0, block_sync_rdy}, 64'd1);
        check_output("hunt_slips", 64'(slip_pulses - base), 64'd1);

        // Reset while locked returns straight to reset values.
        do_reset();

        // Stall: valid every other cycle, lock after 64 valid blocks (127 cycles).
        for (int i = 0; i < 127; i++) begin
            apply_stimulus(i % 2 ? 2'b00 : (i % 4 ? 2'b10 : 2'b01), (i % 2) == 0);
            if (i == 124) begin
                settle();
                check_output("stall_pre", {63'd0, block_sync_rdy}, 64'd0);
            end
        end
        settle();
        check_output("stall_lock", {63'd0, block_sync_rdy}, 64'd1);

        // Twenty hunt errors, each followed by the hold period.
        do_reset();
        for (int k = 0; k < 20; k++) begin
            apply_stimulus(2'b11, 1'b1);
            for (int i = 0; i < SLIP_WAIT; i++) apply_stimulus(2'b00, 1'b1);
        end
        settle();
`ifdef BLOCK_SYNC_HDR_ERR_CNT_EN
        check_output("errcnt_20", {48'd0, hdr_err_count}, 64'd20);
`else
        check_output("errcnt_off", {48'd0, hdr_err_count}, 64'd0);
`endif
        apply_stimulus(2'b01, 1'b0);
        settle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
